// File: rtl/chip_link_tx.sv
// Off-chip transmitter for the 16-bit inter-chip link: serialises one flit into
// link words, MSB word first, each sent with parity over a 4-phase handshake with per-word retry.
module chip_link_tx #(
  parameter int FW             = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flit_valid_i,
  input  logic [FW-1:0]             flit_data_i,
  output logic                      flit_ready_o,
  output logic [CHIPDATA_WIDTH-1:0] link_data_o,
  output logic                      link_valid_o,
  output logic                      link_par_o,
  input  logic                      link_ready_i,
  input  logic                      link_err_i,
  output logic                      busy_o,
  output logic                      err_drop_o,
  output logic [1:0]                dbg_state_o
);

  localparam int CW     = CHIPDATA_WIDTH;
  localparam int NWORDS = FW / CW;
  localparam int IDXW   = $clog2(NWORDS) + 1;
  localparam int RCW    = $clog2(MAX_RETRY + 2);
  localparam logic [IDXW-1:0] NW_LAST = IDXW'(NWORDS);
  localparam logic [RCW-1:0]  RETRY_LIM = RCW'(MAX_RETRY);

  // Handshakes: upstream flit moves on a cycle where flit_valid_i & flit_ready_o;
  // link side is 4-phase: link_valid_o up, link_ready_i up, link_valid_o down,
  // link_ready_i down; link_err_i is only looked at while ready is high.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         flit_q, flit_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [RCW-1:0]        retry_q, retry_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         data_q, data_d;
  logic                  par_q, par_d;
  logic                  drop_q, drop_d;
  logic                  r1_q, r2_q, r3_q, e1_q, e2_q;
  logic                  rdy_h, rdy_l;

  function automatic logic [CW-1:0] word_of(input logic [FW-1:0] f,
                                            input logic [IDXW-1:0] idx);
    word_of = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx == IDXW'(k)) word_of = f[FW-1-k*CW -: CW];
    end
  endfunction

  // Ready needs two consecutive synchronised samples, so a one-cycle glitch never counts.
  assign rdy_h = r2_q & r3_q;
  assign rdy_l = !r2_q & !r3_q;

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    err_d   = err_q;
    data_d  = data_q;
    par_d   = par_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flit_valid_i) begin
          flit_d  = flit_data_i;
          idx_d   = '0;
          retry_d = '0;
          err_d   = 1'b0;
          data_d  = word_of(flit_data_i, '0);
          par_d   = ^word_of(flit_data_i, '0);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (rdy_h) begin
          state_d = WAIT_LOW;
          err_d   = e2_q;
          if (e2_q) begin
            retry_d = retry_q + RCW'(1);
          end else begin
            idx_d   = idx_q + IDXW'(1);
            retry_d = '0;
          end
        end
      end
      WAIT_LOW: begin
        if (rdy_l) begin
          if (idx_q == NW_LAST) begin
            state_d = IDLE;
            data_d  = '0;
            par_d   = 1'b0;
          end else if (err_q && (retry_q > RETRY_LIM)) begin
            state_d = IDLE;
            data_d  = '0;
            par_d   = 1'b0;
            drop_d  = 1'b1;
          end else begin
            // A retried word has an unchanged idx, so it is resent verbatim.
            state_d = DRIVE;
            data_d  = word_of(flit_q, idx_q);
            par_d   = ^word_of(flit_q, idx_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        par_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      flit_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      drop_q  <= 1'b0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      r3_q    <= 1'b0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      data_q  <= data_d;
      par_q   <= par_d;
      drop_q  <= drop_d;
      r1_q    <= link_ready_i;
      r2_q    <= r1_q;
      r3_q    <= r2_q;
      e1_q    <= link_err_i;
      e2_q    <= e1_q;
    end
  end

  assign flit_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign link_valid_o = (state_q == DRIVE);
  assign link_data_o  = data_q;
  assign link_par_o   = par_q;
  assign err_drop_o   = drop_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_chip_link_tx.sv
// Directed bench for chip_link_tx: a receiver task plays the far end while a
// word-sequence model predicts every link word, parity and flit outcome.
module tb_chip_link_tx;

  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flit_valid = 1'b0;
  logic [63:0] flit_data = '0;
  logic        flit_ready;
  logic [15:0] link_data;
  logic        link_valid;
  logic        link_par;
  logic        link_ready = 1'b0;
  logic        link_err = 1'b0;
  logic        busy;
  logic        err_drop;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_w[$];
  logic        obs_p[$];
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data = '0;

  chip_link_tx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flit_valid_i (flit_valid),
    .flit_data_i  (flit_data),
    .flit_ready_o (flit_ready),
    .link_data_o  (link_data),
    .link_valid_o (link_valid),
    .link_par_o   (link_par),
    .link_ready_i (link_ready),
    .link_err_i   (link_err),
    .busy_o       (busy),
    .err_drop_o   (err_drop),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: word k is sent once per attempt; an errored attempt repeats it until
  // more than MAX_RETRY retries have been used, which abandons the flit.
  task automatic build_exp(input logic [63:0] flit, input logic [15:0] errs,
                           output bit drop);
    int h = 0;
    drop = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      int tries = 0;
      for (int a = 0; a < 16; a++) begin
        exp_q.push_back(flit[63-16*k -: 16]);
        h++;
        if (!errs[h-1]) break;
        tries++;
        if (tries > MAX_RETRY) begin
          drop = 1'b1;
          return;
        end
      end
    end
  endtask

  // Continuous checks on every non-reset cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_ready", busy, !flit_ready);
      if (link_valid) chk("par_live", link_par, ^link_data);
      if (link_valid && prev_valid) chk("data_hold", link_data, prev_data);
      if (flit_ready) chk("idle_data", {link_data, link_par}, 17'h0);
    end
    prev_valid = link_valid;
    prev_data  = link_data;
  end

  task automatic run_flit(input logic [63:0] flit, input logic [15:0] errs,
                          input int slow_h0, input bit glitch, input int abort_h,
                          output bit got_drop);
    bit exp_drop;
    int cnt;
    int bad;
    int h = 0;
    logic [15:0] w;
    build_exp(flit, errs, exp_drop);
    obs_w.delete();
    obs_p.delete();
    got_drop = 1'b0;
    cnt = 0;
    while (!flit_ready && cnt < 100) begin @(negedge clk); cnt++; end
    chk("idle_wait", flit_ready, 1'b1);
    flit_valid = 1'b1;
    flit_data  = flit;
    @(negedge clk);
    flit_valid = 1'b0;
    flit_data  = {$urandom, $urandom};
    chk("valid_after_accept", link_valid, 1'b1);
    while (exp_q.size() > 0) begin
      cnt = 0;
      while (!link_valid && cnt < 50) begin @(negedge clk); cnt++; end
      chk("valid_wait", link_valid, 1'b1);
      w = exp_q.pop_front();
      chk("word", link_data, w);
      chk("par", link_par, ^w);
      obs_w.push_back(link_data);
      obs_p.push_back(link_par);
      if (glitch && h == 0) begin
        link_ready = 1'b1;
        @(negedge clk);
        link_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("glitch_valid", link_valid, 1'b1);
        chk("glitch_state", dbg_state, 2'd1);
      end
      bad = 0;
      repeat ((h == 0) ? slow_h0 : 5) begin
        @(negedge clk);
        if (!link_valid || flit_ready || link_data !== w) bad++;
      end
      chk("hold_while_wait", bad, 0);
      link_ready = 1'b1;
      link_err   = errs[h];
      cnt = 0;
      do begin @(posedge clk); cnt++; @(negedge clk); end while (link_valid && cnt < 20);
      chk("fall_latency", cnt, 4);
      if (h == abort_h) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", link_valid, 1'b0);
        chk("abort_data", {link_data, link_par}, 17'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_drop", err_drop, 1'b0);
        chk("abort_ready", flit_ready, 1'b1);
        rst = 1'b0;
        link_ready = 1'b0;
        link_err = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.delete();
        return;
      end
      repeat (5) @(negedge clk);
      link_ready = 1'b0;
      link_err   = 1'b0;
      cnt = 0;
      do begin @(posedge clk); cnt++; @(negedge clk); end
        while (!link_valid && !flit_ready && cnt < 20);
      chk("rise_latency", cnt, 4);
      h++;
    end
    chk("done_idle", flit_ready, 1'b1);
    got_drop = err_drop;
    chk("drop_pulse", err_drop, exp_drop);
    @(negedge clk);
    chk("drop_clear", err_drop, 1'b0);
    repeat (3) @(negedge clk);
    chk("stays_idle", {flit_ready, link_valid}, 2'b10);
  endtask

  initial begin
    bit drop;
    bit dummy;
    repeat (3) @(negedge clk);
    chk("rst_flit_ready", flit_ready, 1'b1);
    chk("rst_outputs", {link_valid, link_data, link_par, busy, err_drop}, 20'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Model pinned against hand-derived sequences.
    build_exp(64'h0001_0003_0007_FFFF, 16'h0002, drop);
    chk("model_t2_len", exp_q.size(), 5);
    chk("model_t2_w2", exp_q[2], 16'h0003);
    build_exp(64'h0001_0003_0007_FFFF, 16'h000F, drop);
    chk("model_t3_len", exp_q.size(), 4);
    chk("model_t3_drop", drop, 1'b1);

    // T1 ideal receiver.
    run_flit(64'h0001_0003_0007_FFFF, 16'h0000, 5, 1'b0, -1, drop);
    chk("t1_len", obs_w.size(), 4);
    if (obs_w.size() == 4) begin
      chk("t1_words", {obs_w[0], obs_w[1], obs_w[2], obs_w[3]}, 64'h0001_0003_0007_FFFF);
      chk("t1_pars", {obs_p[0], obs_p[1], obs_p[2], obs_p[3]}, 4'b1010);
    end
    // T2 single error on word 1.
    run_flit(64'h0001_0003_0007_FFFF, 16'h0002, 5, 1'b0, -1, drop);
    chk("t2_len", obs_w.size(), 5);
    if (obs_w.size() == 5)
      chk("t2_words", {obs_w[1], obs_w[2], obs_w[3]}, 48'h0003_0003_0007);
    chk("t2_no_drop", drop, 1'b0);
    // T3 persistent error on word 0.
    run_flit(64'h0001_0003_0007_FFFF, 16'hFFFF, 5, 1'b0, -1, drop);
    chk("t3_len", obs_w.size(), 4);
    chk("t3_drop", drop, 1'b1);
    // T4 long back-pressure on the first word.
    run_flit(64'hDEAD_BEEF_1234_8000, 16'h0000, 1000, 1'b0, -1, dummy);
    // T5 ready glitch during DRIVE.
    run_flit(64'hA5A5_5A5A_0F0F_F0F0, 16'h0000, 5, 1'b1, -1, dummy);
    // T6 reset in WAIT_LOW of word 2, then a fresh flit from word 0.
    run_flit(64'h0001_0003_0007_FFFF, 16'h0000, 5, 1'b0, 2, dummy);
    run_flit(64'h1111_2222_3333_4444, 16'h0000, 5, 1'b0, -1, dummy);
    if (obs_w.size() > 0) chk("t6_restart_word0", obs_w[0], 16'h1111);
    else chk("t6_restart_len", obs_w.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
